fa4_acc: RTL and testbench

FA4_ACC -- requirements
Module: fa4_acc

---
 rtl/fa4_acc_if.sv | 26 ++
 rtl/fa4_acc.sv | 73 +++++++
 tb/tb_fa4_acc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fa4_acc_if.sv
// Beat/result handshake bundle for fa4_acc: upstream adder beats in, group totals out.
interface fa4_acc_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       s;
  logic             co;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  modport master (
    output in_valid, s, co, in_last, out_ready,
    input  in_ready, out_valid, acc, cnt, ovf
  );

  modport slave (
    input  in_valid, s, co, in_last, out_ready,
    output in_ready, out_valid, acc, cnt, ovf
  );
endinterface

// File: rtl/fa4_acc.sv
// Accumulates 5-bit {co,s} beats from a 4-bit adder into a group total with sticky overflow.
// Define FA4_ACC_SAT_EN to saturate the accumulator at all-ones instead of wrapping.
module fa4_acc #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  fa4_acc_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_beat;

  always_comb begin
    sum       = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, bus.co, bus.s};
    cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // A full counter closes the group even without in_last, so cnt never wraps.
    last_beat = bus.in_last | (cnt_inc == '1);
`ifdef FA4_ACC_SAT_EN
    acc_next  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_next  = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (bus.in_valid) begin
            acc_q <= acc_next;
            cnt_q <= cnt_inc;
            ovf_q <= ovf_q | sum[ACC_W];
            state <= last_beat ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.acc       = acc_q;
  assign bus.cnt       = cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fa4_acc.sv
// Directed-vector bench for fa4_acc with a queue scoreboard checked at each result handshake.
module tb_fa4_acc;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;
  exp_t sb[$];

  fa4_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  fa4_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: any result handshake must match the oldest expected group.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL sb_unexpected: got acc=%0d cnt=%0d ovf=%0d, expected no result",
                 bus.acc, bus.cnt, bus.ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_acc", int'(bus.acc), int'(e.acc));
        check("sb_cnt", int'(bus.cnt), int'(e.cnt));
        check("sb_ovf", int'(bus.ovf), int'(e.ovf));
      end
    end
  end

  task automatic beat(input logic [4:0] v, input logic last);
    bus.in_valid = 1'b1;
    {bus.co, bus.s} = v;
    bus.in_last = last;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    nvec++;
    nmis++;
    $display("FAIL beat_accept: got in_ready=0 for 20 cycles, expected acceptance");
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.s = '0; bus.co = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_acc", int'(bus.acc), 0);
    check("rst_cnt", int'(bus.cnt), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    tick();

    // Basic group 5+9+19 = 33
    bus.out_ready = 1'b1;
    sb.push_back('{acc: 8'd33, cnt: 4'd3, ovf: 1'b0});
    beat(5'd5, 1'b0);
    beat(5'd9, 1'b0);
    beat(5'd19, 1'b1);
    bus.in_valid = 1'b0;
    check("basic_out_valid", int'(bus.out_valid), 1);
    check("basic_acc", int'(bus.acc), 33);
    tick();
    check("basic_clr_acc", int'(bus.acc), 0);
    check("basic_clr_out_valid", int'(bus.out_valid), 0);
    check("basic_clr_in_ready", int'(bus.in_ready), 1);

    // Backpressure: result held, incoming beats ignored
    bus.out_ready = 1'b0;
    sb.push_back('{acc: 8'd33, cnt: 4'd3, ovf: 1'b0});
    beat(5'd5, 1'b0);
    beat(5'd9, 1'b0);
    beat(5'd19, 1'b1);
    {bus.co, bus.s} = 5'd31;
    bus.in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_acc", int'(bus.acc), 33);
      check("bp_cnt", int'(bus.cnt), 3);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_clr_acc", int'(bus.acc), 0);

    // Overflow: 9 x 31 = 279
`ifdef FA4_ACC_SAT_EN
    sb.push_back('{acc: 8'd255, cnt: 4'd9, ovf: 1'b1});
`else
    sb.push_back('{acc: 8'd23, cnt: 4'd9, ovf: 1'b1});
`endif
    for (int i = 0; i < 8; i++) beat(5'd31, 1'b0);
    check("ovf_pre_acc", int'(bus.acc), 248);
    check("ovf_pre_ovf", int'(bus.ovf), 0);
    beat(5'd31, 1'b1);
    bus.in_valid = 1'b0;
    check("ovf_ovf", int'(bus.ovf), 1);
    tick();
    check("ovf_clr_ovf", int'(bus.ovf), 0);

    // Implicit last at cnt = 15
    bus.out_ready = 1'b0;
    sb.push_back('{acc: 8'd15, cnt: 4'd15, ovf: 1'b0});
    for (int i = 0; i < 14; i++) beat(5'd1, 1'b0);
    check("impl_pre_out_valid", int'(bus.out_valid), 0);
    beat(5'd1, 1'b0);
    check("impl_out_valid", int'(bus.out_valid), 1);
    for (int i = 0; i < 2; i++) begin
      check("impl_in_ready", int'(bus.in_ready), 0);
      check("impl_cnt", int'(bus.cnt), 15);
      check("impl_acc", int'(bus.acc), 15);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("impl_clr_cnt", int'(bus.cnt), 0);

    // Reset mid-group overrides a concurrent accept
    beat(5'd7, 1'b0);
    beat(5'd7, 1'b0);
    check("midrst_pre_acc", int'(bus.acc), 14);
    rst = 1'b1;
    bus.in_last = 1'b1;
    tick();
    check("midrst_acc", int'(bus.acc), 0);
    check("midrst_cnt", int'(bus.cnt), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("midrst_idle_out_valid", int'(bus.out_valid), 0);

    // Clean group after reset
    sb.push_back('{acc: 8'd3, cnt: 4'd1, ovf: 1'b0});
    beat(5'd3, 1'b1);
    bus.in_valid = 1'b0;
    tick(); tick();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
